// File: rtl/stream_cipher_pkg.sv
// Shared types for the stream cipher host link.
package stream_cipher_pkg;
  localparam int BYTE_W = 8;

  // Encoding is exported on state_out for debug, keep it stable.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    REL      = 3'd2,
    WAIT_OUT = 3'd3,
    OACK     = 3'd4,
    DELIVER  = 3'd5,
    ERROR    = 3'd6
  } host_state_t;
endpackage

// File: rtl/stream_cipher_host_sync.sv
// Single-bit synchroniser for the asynchronous chip handshake lines.
module hs_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_chain;

  // Shift the raw level through STAGES flops; reset clears the chain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
    end
  end

  assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/stream_cipher_host.sv
// Host-side 4-phase initiator: pushes key/data bytes to the cipher chip and
// collects the encrypted byte for data transfers.
module stream_cipher_host
  import stream_cipher_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [BYTE_W-1:0] i_cmd_byte,
  input  logic              i_cmd_is_key,
  input  logic              i_cmd_reset_hash,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [BYTE_W-1:0] o_res_byte,
  output logic [BYTE_W-1:0] o_input_byte,
  output logic              o_is_key,
  output logic              o_reset_hash,
  output logic              o_input_request,
  input  logic              i_input_acknowledged,
  input  logic              i_output_byte_is_ready,
  output logic              o_output_acknowledge,
  input  logic [BYTE_W-1:0] i_output_byte,
  output logic              o_busy,
  output logic              o_timeout_err,
  input  logic              i_clear_err,
  output logic [2:0]        o_state_out
);
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  host_state_t       r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic              w_ack_s, w_rdy_s, w_accept, w_hit, w_cmd_ready;
  logic [BYTE_W-1:0] r_input_byte, r_res_byte;
  logic              r_is_key, r_reset_hash, r_input_request, r_output_ack;
  logic              r_res_valid, r_timeout_err;

  hs_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_input_acknowledged), .o_q(w_ack_s)
  );
  hs_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rdy (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_output_byte_is_ready), .o_q(w_rdy_s)
  );

  // A stale ack or ready from the chip must clear before a new transfer starts.
  assign w_cmd_ready = !i_rst && (r_state == IDLE) && !w_ack_s && !w_rdy_s && !r_timeout_err;
  // Wait-state timer expiry; the counter restarts on every state change.
  assign w_hit = TO_EN && (r_cnt == TO_LAST);

  // Next-state logic; handshake progress takes priority over an expiring timer.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: if (i_cmd_valid && w_cmd_ready) begin
        w_accept = 1'b1;
        w_next   = REQ;
      end
      REQ:      if (w_ack_s) w_next = REL;
                else if (w_hit) w_next = ERROR;
      REL:      if (!w_ack_s) w_next = r_is_key ? IDLE : WAIT_OUT;
                else if (w_hit) w_next = ERROR;
      WAIT_OUT: if (w_rdy_s) w_next = OACK;
                else if (w_hit) w_next = ERROR;
      OACK:     if (!w_rdy_s) w_next = DELIVER;
                else if (w_hit) w_next = ERROR;
      DELIVER:  if (i_res_ready) w_next = IDLE;
      ERROR:    if (i_clear_err) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // State register and saturating wait-state counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)   r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Chip-side and result registers, updated on the FSM transitions.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_input_byte    <= '0;
      r_is_key        <= 1'b0;
      r_reset_hash    <= 1'b0;
      r_input_request <= 1'b0;
      r_output_ack    <= 1'b0;
      r_res_byte      <= '0;
      r_res_valid     <= 1'b0;
      r_timeout_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_input_byte    <= i_cmd_byte;
        r_is_key        <= i_cmd_is_key;
        r_reset_hash    <= i_cmd_reset_hash;
        r_input_request <= 1'b1;
      end
      if (r_state == REQ && w_next == REL) r_input_request <= 1'b0;
      // Bus is only released once the chip has dropped its ack.
      if (r_state == REL && w_next != REL) begin
        r_input_byte <= '0;
        r_is_key     <= 1'b0;
        r_reset_hash <= 1'b0;
      end
      if (r_state == WAIT_OUT && w_next == OACK) begin
        r_res_byte   <= i_output_byte;
        r_output_ack <= 1'b1;
      end
      if (r_state == OACK && w_next == DELIVER) begin
        r_output_ack <= 1'b0;
        r_res_valid  <= 1'b1;
      end
      if (r_state == DELIVER && w_next == IDLE) r_res_valid <= 1'b0;
      if (w_next == ERROR && r_state != ERROR) begin
        r_timeout_err   <= 1'b1;
        r_input_byte    <= '0;
        r_is_key        <= 1'b0;
        r_reset_hash    <= 1'b0;
        r_input_request <= 1'b0;
        r_output_ack    <= 1'b0;
        r_res_valid     <= 1'b0;
      end
      if (r_state == ERROR && w_next == IDLE) r_timeout_err <= 1'b0;
    end
  end

  assign o_cmd_ready          = w_cmd_ready;
  assign o_res_valid          = r_res_valid;
  assign o_res_byte           = r_res_byte;
  assign o_input_byte         = r_input_byte;
  assign o_is_key             = r_is_key;
  assign o_reset_hash         = r_reset_hash;
  assign o_input_request      = r_input_request;
  assign o_output_acknowledge = r_output_ack;
  assign o_busy               = (r_state != IDLE);
  assign o_timeout_err        = r_timeout_err;
  assign o_state_out          = r_state;
endmodule
